change_dispense_sequencer: RTL and testbench

CHANGE_DISPENSE_SEQUENCER -- requirements
Module: change_dispense_sequencer

---
 rtl/change_dispense_sequencer.sv | 146 ++++++++++++++
 tb/tb_change_dispense_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_sequencer.sv
// Change dispenser: pays out an amount greedily, largest coin first,
// one four-phase eject/ack handshake per coin, with timeout protection.
module change_dispense_sequencer #(
    parameter int          DENOM0      = 100,
    parameter int          DENOM1      = 25,
    parameter int          DENOM2      = 10,
    parameter int          DENOM3      = 5,
    parameter logic [27:0] ACK_TIMEOUT = 28'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] changeAmount,
    input  logic [3:0]  tubeEmpty,
    input  logic        ejectAck,
    output logic [3:0]  eject,
    output logic        busy,
    output logic        done,
    output logic        shortfall,
    output logic        fault,
    output logic [11:0] remaining,
    output logic [7:0]  coinCount
);

    typedef enum logic [2:0] {
        IDLE, SELECT, EJECT, RELEASE, DONE, FAULT
    } state_t;

    localparam logic [3:0][11:0] DEN = {
        12'(DENOM3), 12'(DENOM2), 12'(DENOM1), 12'(DENOM0)
    };

    state_t      state, state_n;
    logic [3:0]  eject_n;
    logic [11:0] rem_n;
    logic [7:0]  cnt_n;
    logic        short_n, fault_n;
    logic [27:0] tmo, tmo_n;
    logic [1:0]  sel, sel_n;
    logic [1:0]  pick;
    logic        found;
    logic        tmo_last;

    // Scan high to low so the last hit is the largest eligible coin.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (DEN[i] <= remaining && !tubeEmpty[i]) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    assign tmo_last = (tmo == ACK_TIMEOUT - 28'd1);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) || (state == FAULT);

    always_comb begin
        state_n = state;
        eject_n = eject;
        rem_n   = remaining;
        cnt_n   = coinCount;
        short_n = shortfall;
        fault_n = fault;
        tmo_n   = tmo;
        sel_n   = sel;
        unique case (state)
            IDLE: begin
                if (start) begin
                    rem_n   = changeAmount;
                    cnt_n   = 8'd0;
                    short_n = 1'b0;
                    fault_n = 1'b0;
                    state_n = SELECT;
                end
            end
            SELECT: begin
                tmo_n = 28'd0;
                if (remaining == 12'd0) begin
                    state_n = DONE;
                end else if (found) begin
                    sel_n   = pick;
                    eject_n = 4'(1) << pick;
                    state_n = EJECT;
                end else begin
                    short_n = 1'b1;
                    state_n = DONE;
                end
            end
            EJECT: begin
                if (ejectAck) begin
                    eject_n = 4'd0;
                    rem_n   = remaining - DEN[sel];
                    cnt_n   = (coinCount == 8'hFF) ? coinCount
                                                   : coinCount + 8'd1;
                    tmo_n   = 28'd0;
                    state_n = RELEASE;
                end else if (tmo_last) begin
                    eject_n = 4'd0;
                    fault_n = 1'b1;
                    state_n = FAULT;
                end else begin
                    tmo_n = tmo + 28'd1;
                end
            end
            RELEASE: begin
                if (!ejectAck) begin
                    state_n = SELECT;
                end else if (tmo_last) begin
                    fault_n = 1'b1;
                    state_n = FAULT;
                end else begin
                    tmo_n = tmo + 28'd1;
                end
            end
            DONE:    state_n = IDLE;
            FAULT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            eject     <= 4'd0;
            remaining <= 12'd0;
            coinCount <= 8'd0;
            shortfall <= 1'b0;
            fault     <= 1'b0;
            tmo       <= 28'd0;
            sel       <= 2'd0;
        end else begin
            state     <= state_n;
            eject     <= eject_n;
            remaining <= rem_n;
            coinCount <= cnt_n;
            shortfall <= short_n;
            fault     <= fault_n;
            tmo       <= tmo_n;
            sel       <= sel_n;
        end
    end

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Scoreboard bench for change_dispense_sequencer: expected coins and
// completion records are queued by stimulus and checked by a monitor.
module tb_change_dispense_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] changeAmount = '0;
    logic [3:0]  tubeEmpty = '0;
    logic        ejectAck = 1'b0;
    logic [3:0]  eject;
    logic        busy, done, shortfall, fault;
    logic [11:0] remaining;
    logic [7:0]  coinCount;

    typedef struct {
        int cnt;
        int rem;
        int sf;
        int flt;
    } exp_t;

    int   exp_coins[$];
    exp_t exp_done[$];
    int   compared = 0;
    int   mism = 0;
    bit   ack_en = 1'b1;

    change_dispense_sequencer #(.ACK_TIMEOUT(28'd16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .changeAmount(changeAmount), .tubeEmpty(tubeEmpty),
        .ejectAck(ejectAck), .eject(eject), .busy(busy), .done(done),
        .shortfall(shortfall), .fault(fault), .remaining(remaining),
        .coinCount(coinCount)
    );

    always #5 clock = ~clock;

    function automatic int coin_val(logic [3:0] e);
        case (e)
            4'b0001: return 100;
            4'b0010: return 25;
            4'b0100: return 10;
            4'b1000: return 5;
            default: return 0;
        endcase
    endfunction

    task automatic check(string nm, int got, int want);
        compared++;
        if (got != want) begin
            mism++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic push_done(int c, int r, int s, int f);
        exp_t e;
        e.cnt = c; e.rem = r; e.sf = s; e.flt = f;
        exp_done.push_back(e);
    endtask

    // Monitor: new eject and done pulses are checked against the queues.
    initial begin
        logic [3:0] prev = '0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && eject != 0 && prev == 0) begin
                if (exp_coins.size() == 0)
                    check("unexpected_eject", int'(eject), 0);
                else
                    check("coin", coin_val(eject), exp_coins.pop_front());
            end
            if (!reset && done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_done.pop_front();
                    check("done_coinCount", int'(coinCount), e.cnt);
                    check("done_remaining", int'(remaining), e.rem);
                    check("done_shortfall", int'(shortfall), e.sf);
                    check("done_fault", int'(fault), e.flt);
                    check("done_eject", int'(eject), 0);
                end
            end
            prev = eject;
        end
    end

    // Coin mechanism: ack two cycles after eject, drop once eject clears.
    initial begin
        forever begin
            @(negedge clock);
            if (ack_en && eject != 0 && !reset) begin
                int g = 0;
                repeat (2) @(posedge clock);
                #1 ejectAck = 1'b1;
                while (eject != 0 && g < 50) begin
                    @(posedge clock);
                    #1 g++;
                end
                ejectAck = 1'b0;
            end
        end
    end

    task automatic go(int amt, logic [3:0] tubes);
        @(posedge clock);
        #1;
        start = 1'b1;
        changeAmount = 12'(amt);
        tubeEmpty = tubes;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 500);
        if (!done) check({nm, "_timeout"}, 0, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n, hi;
        #1;
        check("rst_eject", int'(eject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_coinCount", int'(coinCount), 0);
        check("rst_flags", int'({shortfall, fault}), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        exp_coins = {25, 25, 10, 5};
        push_done(4, 0, 0, 0);
        go(65, 4'b0000);
        wait_done("amt65");

        exp_coins = {25, 25, 25, 25, 25, 10, 5};
        push_done(7, 0, 0, 0);
        go(140, 4'b0001);
        wait_done("amt140");

        push_done(0, 0, 0, 0);
        go(0, 4'b0000);
        check("zero_n1_busy", int'(busy), 1);
        check("zero_n1_done", int'(done), 0);
        @(posedge clock);
        #1 check("zero_n2_done", int'(done), 1);
        @(posedge clock);
        #1;
        check("zero_n3_done", int'(done), 0);
        check("zero_n3_busy", int'(busy), 0);
        check("zero_coinCount", int'(coinCount), 0);

        ack_en = 1'b0;
        exp_coins = {25};
        push_done(0, 25, 0, 1);
        go(25, 4'b0000);
        n = 0;
        hi = 0;
        do begin
            @(negedge clock);
            if (eject != 0) hi++;
            n++;
        end while (!done && n < 100);
        check("tmo_done_seen", int'(done), 1);
        check("tmo_eject_cycles", hi, 16);
        @(posedge clock);
        #1;
        check("tmo_fault_hold", int'(fault), 1);
        check("tmo_idle", int'(busy), 0);
        ack_en = 1'b1;

        exp_coins = {10};
        push_done(1, 3, 1, 0);
        go(13, 4'b0000);
        wait_done("amt13");

        ack_en = 1'b0;
        exp_coins = {25};
        go(25, 4'b0000);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (eject != 4'b0010 && n < 20);
        check("rst_mid_eject_seen", int'(eject), 2);
        reset = 1'b1;
        #1;
        check("rst_mid_eject", int'(eject), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_remaining", int'(remaining), 0);
        check("rst_mid_coinCount", int'(coinCount), 0);
        check("rst_mid_flags", int'({shortfall, fault}), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge clock);
            if (done || busy) hi++;
        end
        check("rst_mid_quiet", hi, 0);
        ack_en = 1'b1;

        exp_coins = {25, 25, 10, 5};
        push_done(4, 0, 0, 0);
        go(65, 4'b0000);
        wait_done("after_rst");

        check("coins_left", exp_coins.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
